// File: rtl/alu_pkg.sv
// alu_pkg: op codes and sequencer state encoding shared by the ALU and its sequencer
package alu_pkg;
   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_SHL  = 3'd5;
   localparam logic [2:0] OP_SHR  = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
endpackage

// File: rtl/alu.sv
// alu: combinational WIDTH-bit ALU; carry_o is add carry, sub borrow, or the bit shifted out
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       sel_i,
   output logic [WIDTH-1:0] out_o,
   output logic             carry_o
);
   always_comb begin
      {carry_o, out_o} = '0;
      case (sel_i)
         OP_ADD:  {carry_o, out_o} = {1'b0, a_i} + {1'b0, b_i};
         OP_SUB:  {carry_o, out_o} = {1'b0, a_i} - {1'b0, b_i};
         OP_AND:  out_o = a_i & b_i;
         OP_OR:   out_o = a_i | b_i;
         OP_XOR:  out_o = a_i ^ b_i;
         OP_SHL:  {carry_o, out_o} = {a_i, 1'b0};
         OP_SHR:  {out_o, carry_o} = {1'b0, a_i};
         default: out_o = a_i;
      endcase
   end
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin grant; the pointer flips to the loser after every grant
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [1:0] valid_i,
   output logic [1:0] gnt_o
);
   logic ptr_q, ptr_d;
   assign gnt_o[0] = en_i & valid_i[0] & (~valid_i[1] | ~ptr_q);
   assign gnt_o[1] = en_i & valid_i[1] & (~valid_i[0] | ptr_q);
   assign ptr_d    = |gnt_o ? gnt_o[0] : ptr_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
endmodule

// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer: round-robin sharing of one ALU between two requesters with a tagged response.
// Define ALU_RR_SEQUENCER_STATS_EN to add saturating per-requester grant counters.
module alu_rr_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
   output logic             rsp_zero,
   output logic             busy
`ifdef ALU_RR_SEQUENCER_STATS_EN
   ,output logic [CNT_W-1:0] gnt_cnt0
   ,output logic [CNT_W-1:0] gnt_cnt1
`endif
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, alu_out;
   logic [2:0]       op_q, op_d;
   logic             id_q, id_d, vld_q, vld_d, rid_q, rid_d, cy_q, cy_d, zr_q, zr_d;
   logic [1:0]       gnt;
   logic             en, hs, exec, rsp_done, alu_cy;
   assign exec     = state_q == EXEC;
   assign rsp_done = state_q == RESP && rsp_ready;
   // rst_n gates arbitration so no ready can leak out while reset is held
   assign en       = rst_n && (state_q == IDLE || rsp_done);
   assign hs       = |gnt;
   rr_arb2 u_arb (.clk(clk), .rst_n(rst_n), .en_i(en), .valid_i({req1_valid, req0_valid}), .gnt_o(gnt));
   alu #(.WIDTH(WIDTH)) u_alu (.a_i(a_q), .b_i(b_q), .sel_i(op_q), .out_o(alu_out), .carry_o(alu_cy));
   always_comb begin
      state_d = exec ? RESP : (state_q == RESP && !rsp_ready) ? RESP : hs ? EXEC : IDLE;
      a_d     = hs ? (gnt[1] ? req1_a : req0_a) : a_q;
      b_d     = hs ? (gnt[1] ? req1_b : req0_b) : b_q;
      op_d    = hs ? (gnt[1] ? req1_op : req0_op) : op_q;
      id_d    = hs ? gnt[1] : id_q;
      vld_d   = exec | (vld_q & ~rsp_done);
      rid_d   = exec ? id_q : rid_q;
      res_d   = exec ? alu_out : res_q;
      cy_d    = exec ? alu_cy : cy_q;
      zr_d    = exec ? (alu_out == '0) : zr_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         id_q    <= 1'b0;
         vld_q   <= 1'b0;
         rid_q   <= 1'b0;
         res_q   <= '0;
         cy_q    <= 1'b0;
         zr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         id_q    <= id_d;
         vld_q   <= vld_d;
         rid_q   <= rid_d;
         res_q   <= res_d;
         cy_q    <= cy_d;
         zr_q    <= zr_d;
      end
   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];
   assign rsp_valid  = vld_q;
   assign rsp_id     = rid_q;
   assign rsp_result = res_q;
   assign rsp_carry  = cy_q;
   assign rsp_zero   = zr_q;
   assign busy       = state_q != IDLE;
`ifdef ALU_RR_SEQUENCER_STATS_EN
   logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   assign cnt0_d = cnt0_q + CNT_W'(gnt[0] && !(&cnt0_q));
   assign cnt1_d = cnt1_q + CNT_W'(gnt[1] && !(&cnt1_q));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   assign gnt_cnt0 = cnt0_q;
   assign gnt_cnt1 = cnt1_q;
`endif
endmodule
